fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
// - Instruction-fetch front end: owns the PC register, issues word reads to instruction memory via a req/ack
//   handshake and presents one instruction (raw word plus split fields and pc_4) to decode/execute.
// - Consumes the execute stage's pc_result when that instruction retires, closing the PC loop.
// - Sits between the instruction-memory port and Stage_2/Stage_3.
// PARAMETERS
// - RESET_PC  32'h0000_3000  PC loaded on reset; must be word aligned.
// - TIMEOUT   16             Max cycles in FETCH without imem_ack before fetch_err; legal range 2..255.
// PORTS
// - clk          in   1   Single clock; all state updates on rising edge.
// - rst          in   1   Reset; synchronous, active-high.
// - imem_req     out  1   Read request to instruction memory.
// - imem_addr    out  32  Byte address of the word requested; equals pc.
// - imem_ack     in   1   Memory ack; imem_rdata is valid in the same cycle.
// - imem_rdata   in   32  Instruction word.
// - retire       in   1   Downstream has finished the presented instruction; pc_result is valid this cycle.
// - pc_result    in   32  Next PC from execute (branch/jr/j/eret/pc_4 select).
// - instr_valid  out  1   instr and all fields are valid.
// - instr        out  32  Raw instruction word.
// - pc           out  32  Address of the presented instruction.
// - pc_4         out  32  pc + 4, modulo 2^32.
// - op/rs/rt/rd/sa/func  out  6/5/5/5/5/6  instr[31:26]/[25:21]/[20:16]/[15:11]/[10:6]/[5:0].
// - imm          out  16  instr[15:0].
// - instr_index  out  26  instr[25:0].
// - fetch_err    out  1   Sticky error: fetch timeout or misaligned pc_result.
// BEHAVIOUR
// - Reset values: pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr=0, fetch_err=0, wait count=0.
// - rst overrides every other input in the same cycle.
// - States:
//   - IDLE: next edge -> FETCH.
//   - FETCH: imem_req=1; imem_addr=pc, held stable until ack.
//     On imem_ack: instr<=imem_rdata, instr_valid<=1, go to HOLD.
//     Without ack: counter+1; when the counter reaches TIMEOUT -> ERR.
//   - HOLD: imem_req=0; outputs frozen.
//     On retire: instr_valid<=0; if pc_result[1:0]==0, pc<=pc_result and go to FETCH; else go to ERR.
//   - ERR: fetch_err=1, imem_req=0, instr_valid=0; leaves only on rst.
// - Latency and throughput:
//   - Ack may arrive in the same cycle req first rises, giving instr_valid one cycle after entry to FETCH.
//   - Minimum 2 cycles per instruction (FETCH + HOLD).
// - Ignored inputs:
//   - imem_ack outside FETCH; a late ack after rst or after timeout is dropped.
//   - retire outside HOLD.
// - Simultaneous events: in FETCH, imem_ack and counter==TIMEOUT in the same cycle -> ack wins.
// - Field outputs are combinational slices of the registered instr; pc_4 = pc + 32'd4 (32'hFFFF_FFFC -> 0).
// - The wait counter clears on every FETCH entry.
// STRUCTURE
// - Shared header fetch_defs.vh: state encodings (IDLE/FETCH/HOLD/ERR, 2 bits), field bit positions,
//   default RESET_PC. The decode stage reuses it.
// - Sub-module instr_field_split: purely combinational instr -> op/rs/rt/rd/sa/func/imm/instr_index.
//   Decode reuses it.
// - Top: FSM, PC register, wait counter.
// TESTING
// - Reset, zero-wait memory: rst 2 cycles, memory acks same cycle with 32'h2008_0005.
//   -> imem_addr=32'h3000; instr_valid 1 cycle after FETCH; op=6'h08, rt=8, imm=16'h0005; pc_4=32'h3004.
// - Retire loop: retire with pc_result=32'h3004, memory latency 3 cycles.
//   -> imem_addr=32'h3004 stable over 3 req cycles; instr_valid only after ack; pc=32'h3004.
// - Branch redirect: retire with pc_result=32'h3100.
//   -> next imem_addr=32'h3100, no fetch of 32'h3008.
// - Timeout: memory never acks, TIMEOUT=16.
//   -> fetch_err=1 after 16 FETCH cycles; imem_req=0; a later ack has no effect; rst clears to IDLE.
// - Misalignment and wrap:
//   - pc_result=32'h3002 -> ERR, fetch_err=1.
//   - pc=32'hFFFF_FFFC -> pc_4=0.
// - Reset mid-wait: rst asserted during FETCH with ack in the same cycle.
//   -> instr_valid stays 0; pc=RESET_PC next cycle.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: FSM state encodings, instruction field
// positions and the default reset PC.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // LSB position of each instruction field; widths are fixed by the ISA.
  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SA_LSB = 6;

endpackage

// File: rtl/fetch_stage_instr_field_split.sv
// Purely combinational split of a 32-bit instruction word into its fields.
// Shared with the decode stage.
module instr_field_split
  import fetch_stage_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [5:0]  func,
  output logic [15:0] imm,
  output logic [25:0] instr_index
);

  assign op          = instr[OP_LSB +: 6];
  assign rs          = instr[RS_LSB +: 5];
  assign rt          = instr[RT_LSB +: 5];
  assign rd          = instr[RD_LSB +: 5];
  assign sa          = instr[SA_LSB +: 5];
  assign func        = instr[5:0];
  assign imm         = instr[15:0];
  assign instr_index = instr[25:0];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, imem req/ack FSM with a fetch
// timeout, and the presented instruction with its decoded fields.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        retire,
  input  logic [31:0] pc_result,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [5:0]  func,
  output logic [15:0] imm,
  output logic [25:0] instr_index,
  output logic        fetch_err,
  output logic [1:0]  fsm_state
);

  // Handshake: imem_req is high for every FETCH cycle with imem_addr held at pc;
  // a cycle with imem_req && imem_ack transfers imem_rdata. retire is only
  // honoured while instr_valid is high (HOLD); it is ignored elsewhere.

  fetch_state_t state, state_next;
  logic [7:0]   wait_cnt;
  logic         timeout_hit;
  logic         target_aligned;

  // The counter reaches TIMEOUT on the edge that ends the TIMEOUT-th unacked cycle.
  assign timeout_hit    = (wait_cnt == 8'(TIMEOUT - 1));
  assign target_aligned = (pc_result[1:0] == 2'b00);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH: begin
        if (imem_ack)         state_next = HOLD;
        else if (timeout_hit) state_next = ERR;
      end
      HOLD: begin
        if (retire) state_next = target_aligned ? FETCH : ERR;
      end
      ERR:     state_next = ERR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: wait_cnt <= '0;
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (retire) begin
            instr_valid <= 1'b0;
            wait_cnt    <= '0;
            if (target_aligned) pc <= pc_result;
          end
        end
        default: instr_valid <= 1'b0;
      endcase
    end
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign pc_4      = pc + 32'd4;
  assign fetch_err = (state == ERR);
  assign fsm_state = state;

  instr_field_split u_split (
    .instr       (instr),
    .op          (op),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .sa          (sa),
    .func        (func),
    .imm         (imm),
    .instr_index (instr_index)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory responses are driven step by step and
// every accepted word is queued, then popped when instr_valid presents it.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        retire;
  logic [31:0] pc_result;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, sa;
  logic [5:0]  func;
  logic [15:0] imm;
  logic [25:0] instr_index;
  logic        fetch_err;
  logic [1:0]  fsm_state;

  logic [31:0] exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  // Clock/reset block
  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_3000), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .retire      (retire),
    .pc_result   (pc_result),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .pc_4        (pc_4),
    .op          (op),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .sa          (sa),
    .func        (func),
    .imm         (imm),
    .instr_index (instr_index),
    .fetch_err   (fetch_err),
    .fsm_state   (fsm_state)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Driver: present an ack with data this cycle and queue the expected word.
  task automatic mem_ack(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    exp_q.push_back(word);
  endtask

  task automatic check_presented(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
      check({tag, "_instr"}, instr, e);
    end
  endtask

  task automatic do_retire(input logic [31:0] target);
    retire    = 1'b1;
    pc_result = target;
    step();
    retire    = 1'b0;
  endtask

  initial begin
    int req_cycles;
    logic [31:0] w;

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; retire = 1'b0; pc_result = '0;
    step(); step();

    // Reset state
    check("rst_state", {30'd0, fsm_state}, 32'(IDLE));
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);

    // Zero-wait memory: ack in the first FETCH cycle
    rst = 1'b0;
    step();
    check("zw_req", {31'd0, imem_req}, 32'd1);
    check("zw_addr", imem_addr, 32'h0000_3000);
    check("zw_valid_before", {31'd0, instr_valid}, 32'd0);
    mem_ack(32'h2008_0005);
    step();
    imem_ack = 1'b0;
    check_presented("zw");
    check("zw_op", {26'd0, op}, 32'h08);
    check("zw_rt", {27'd0, rt}, 32'd8);
    check("zw_imm", {16'd0, imm}, 32'h0005);
    check("zw_pc_4", pc_4, 32'h0000_3004);
    check("zw_req_hold", {31'd0, imem_req}, 32'd0);
    // Outputs stay frozen in HOLD with no retire, and a stray ack is ignored.
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    check("hold_frozen", instr, 32'h2008_0005);
    check("hold_valid", {31'd0, instr_valid}, 32'd1);

    // Retire loop with 3-cycle memory latency
    do_retire(32'h0000_3004);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lat_req%0d", i), {31'd0, imem_req}, 32'd1);
      check($sformatf("lat_addr%0d", i), imem_addr, 32'h0000_3004);
      check($sformatf("lat_valid%0d", i), {31'd0, instr_valid}, 32'd0);
      if (i == 0) begin
        retire = 1'b1; pc_result = 32'h0000_3002;  // retire outside HOLD is ignored
      end else begin
        retire = 1'b0;
      end
      if (i == 2) mem_ack(32'h012A_4020);
      step();
    end
    imem_ack = 1'b0;
    check_presented("lat");
    check("lat_pc", pc, 32'h0000_3004);
    check("lat_err", {31'd0, fetch_err}, 32'd0);
    check("lat_rs", {27'd0, rs}, 32'd9);
    check("lat_rt", {27'd0, rt}, 32'd10);
    check("lat_rd", {27'd0, rd}, 32'd8);
    check("lat_sa", {27'd0, sa}, 32'd0);
    check("lat_func", {26'd0, func}, 32'h20);

    // Branch redirect
    do_retire(32'h0000_3100);
    check("br_addr", imem_addr, 32'h0000_3100);
    check("br_req", {31'd0, imem_req}, 32'd1);
    w = $urandom_range(32'h7FFF_FFFF, 0) | 32'h0800_0000;
    mem_ack(w);
    step();
    imem_ack = 1'b0;
    check_presented("br");
    check("br_index", {6'd0, instr_index}, {6'd0, w[25:0]});

    // Wrap at top of address space
    do_retire(32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_pc_4", pc_4, 32'h0000_0000);
    mem_ack(32'h0C00_0ABC);
    step();
    imem_ack = 1'b0;
    check_presented("wrap");

    // Misaligned redirect goes to ERR and stays there
    do_retire(32'h0000_3002);
    check("mis_err", {31'd0, fetch_err}, 32'd1);
    check("mis_req", {31'd0, imem_req}, 32'd0);
    check("mis_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1; retire = 1'b1; pc_result = 32'h0000_3000;
    step();
    imem_ack = 1'b0; retire = 1'b0;
    check("mis_sticky", {30'd0, fsm_state}, 32'(ERR));

    // Reset clears ERR
    rst = 1'b1;
    step();
    check("err_rst_state", {30'd0, fsm_state}, 32'(IDLE));
    check("err_rst_err", {31'd0, fetch_err}, 32'd0);
    check("err_rst_pc", pc, 32'h0000_3000);
    rst = 1'b0;
    step();

    // Timeout: memory never acks; bounded count of request cycles
    req_cycles = 0;
    for (int i = 0; i < 40 && imem_req; i++) begin
      req_cycles++;
      step();
    end
    check("to_req_cycles", req_cycles, 32'd16);
    check("to_err", {31'd0, fetch_err}, 32'd1);
    check("to_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    check("to_late_ack_valid", {31'd0, instr_valid}, 32'd0);
    check("to_late_ack_err", {31'd0, fetch_err}, 32'd1);

    // Reset mid-wait with a simultaneous ack
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    check("rmw_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
    step();
    rst = 1'b0; imem_ack = 1'b0;
    check("rmw_valid", {31'd0, instr_valid}, 32'd0);
    check("rmw_pc", pc, 32'h0000_3000);
    check("rmw_state", {30'd0, fsm_state}, 32'(IDLE));

    // Ack on the final allowed cycle wins over the timeout
    step();
    for (int i = 0; i < 15; i++) step();
    check("edge_req", {31'd0, imem_req}, 32'd1);
    mem_ack(32'h3C01_1234);
    step();
    imem_ack = 1'b0;
    check_presented("edge");
    check("edge_err", {31'd0, fetch_err}, 32'd0);

    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
